// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - op codes, flag indices and FSM states shared by alu_pipe
package alu_pipe_pkg;

  // Function select sel[4:2]; sel[1:0] are the operand inverts.
  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_OR   = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SHR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_MUL  = 3'd7
  } op_e;

  // Bit positions inside the 4-bit status word.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef logic [0:0] state_t;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_pipe_mul.sv
// rtl/alu_pipe_mul.sv - iterative shift-add unsigned multiplier, one step per cycle
//   clk, rst : clock, synchronous active-high reset (aborts a running multiply)
//   start    : latch a/b and begin WIDTH steps
//   a, b     : operands
//   done     : high during the final step; product is valid in that same cycle
//   product  : full 2*WIDTH-bit product including the current step
module alu_pipe_mul #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic               active;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_step;

  // The step is exposed combinationally so the caller can load the final
  // product on the same edge as the last step instead of one cycle later.
  always_comb begin
    acc_step = acc;
    if (mplier[0]) begin
      acc_step = acc + mcand;
    end
  end

  assign done    = active && (cnt == CW'(WIDTH - 1));
  assign product = acc_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (active) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake and iterative multiply
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : input handshake for a, b, cin, sel
//   a, b, cin            : operands and adder carry-in
//   sel                  : [0] invert a, [1] invert b, [4:2] op code
//   out_valid, out_ready : output handshake for out/status
//   out, status          : registered result and flags {N,V,C,Z}
//   ALU_PIPE_STICKY_EN   : adds clr_sticky (in) and sticky[1:0] = {V,C} (out)
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [4:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       status
`ifdef ALU_PIPE_STICKY_EN
  ,
  input  logic             clr_sticky,
  output logic [1:0]       sticky
`endif
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  op_e                op;
  logic [WIDTH-1:0]   a_eff;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               load;
  logic [WIDTH-1:0]   load_res;
  logic               load_c;
  logic               load_v;
  logic [3:0]         load_status;

  assign op    = op_e'(sel[4:2]);
  assign a_eff = sel[0] ? ~a : a;
  assign b_eff = sel[1] ? ~b : b;
  assign sum   = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  // A new op is only taken when idle and the output register is free or
  // being drained this cycle, which gives full-rate back-to-back single ops.
  assign in_ready  = ~rst & (state == ST_IDLE) & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (op == OP_MUL);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ZERO: alu_res = '0;
      OP_OR:   alu_res = a_eff | b_eff;
      OP_AND:  alu_res = a_eff & b_eff;
      OP_XOR:  alu_res = a_eff ^ b_eff;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~(a_eff[WIDTH-1] ^ b_eff[WIDTH-1]) & (a_eff[WIDTH-1] ^ sum[WIDTH-1]);
      end
      // Shifts use the raw operand; the amount is masked to SHW bits.
      OP_SHR:  alu_res = a >> b[SHW-1:0];
      OP_SHL:  alu_res = a << b[SHW-1:0];
      OP_MUL:  alu_res = '0;
    endcase
  end

  alu_pipe_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a_eff),
    .b       (b_eff),
    .done    (mul_done),
    .product (mul_product)
  );

  // While in MUL no new op can be accepted, so the state alone picks the source.
  always_comb begin
    if (state == ST_MUL) begin
      load     = mul_done;
      load_res = mul_product[WIDTH-1:0];
      load_c   = 1'b0;
      load_v   = |mul_product[2*WIDTH-1:WIDTH];
    end else begin
      load     = accept & (op != OP_MUL);
      load_res = alu_res;
      load_c   = alu_c;
      load_v   = alu_v;
    end
  end

  always_comb begin
    load_status         = '0;
    load_status[FLAG_Z] = (load_res == '0);
    load_status[FLAG_C] = load_c;
    load_status[FLAG_V] = load_v;
    load_status[FLAG_N] = load_res[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (mul_start) begin
        state <= ST_MUL;
      end
    end else if (mul_done) begin
      state <= ST_IDLE;
    end
  end

  // A load in the same cycle as a consume keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      status    <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= load_res;
      status    <= load_status;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_PIPE_STICKY_EN
  logic [1:0] sticky_base;

  // Clear first, then OR in the flags of a result loading on the same edge.
  assign sticky_base = clr_sticky ? 2'b00 : sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 2'b00;
    end else if (load) begin
      sticky <= sticky_base | {load_v, load_c};
    end else begin
      sticky <= sticky_base;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe at WIDTH 64 and 8
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total  = 0;
  int   passed = 0;

  logic        in_valid_w, in_ready_w, cin_w, out_valid_w, out_ready_w;
  logic [4:0]  sel_w;
  logic [63:0] a_w, b_w, out_w;
  logic [3:0]  status_w;

  logic        in_valid_s, in_ready_s, cin_s, out_valid_s, out_ready_s;
  logic [4:0]  sel_s;
  logic [7:0]  a_s, b_s, out_s;
  logic [3:0]  status_s;

`ifdef ALU_PIPE_STICKY_EN
  logic        clr_sticky_w, clr_sticky_s;
  logic [1:0]  sticky_w, sticky_s;
`endif

  alu_pipe #(.WIDTH(64)) u_alu64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_w),
    .in_ready  (in_ready_w),
    .a         (a_w),
    .b         (b_w),
    .cin       (cin_w),
    .sel       (sel_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready_w),
    .out       (out_w),
    .status    (status_w)
`ifdef ALU_PIPE_STICKY_EN
    ,
    .clr_sticky (clr_sticky_w),
    .sticky     (sticky_w)
`endif
  );

  alu_pipe #(.WIDTH(8)) u_alu8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .a         (a_s),
    .b         (b_s),
    .cin       (cin_s),
    .sel       (sel_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .out       (out_s),
    .status    (status_s)
`ifdef ALU_PIPE_STICKY_EN
    ,
    .clr_sticky (clr_sticky_s),
    .sticky     (sticky_s)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic [4:0] sel);
    a_w = a; b_w = b; cin_w = cin; sel_w = sel; in_valid_w = 1'b1;
    tick();
    in_valid_w = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [4:0] sel);
    a_s = a; b_s = b; cin_s = cin; sel_s = sel; in_valid_s = 1'b1;
    tick();
    in_valid_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (out_valid_w !== 1'b0) $display("FAIL reset_out_valid64 got %b want 0", out_valid_w); else passed++;
    total++; if (out_w !== 64'd0) $display("FAIL reset_out64 got %h want 0", out_w); else passed++;
    total++; if (status_w !== 4'd0) $display("FAIL reset_status64 got %b want 0000", status_w); else passed++;
    total++; if (in_ready_w !== 1'b0) $display("FAIL reset_in_ready64 got %b want 0", in_ready_w); else passed++;
    total++; if (out_valid_s !== 1'b0) $display("FAIL reset_out_valid8 got %b want 0", out_valid_s); else passed++;
    total++; if (in_ready_s !== 1'b0) $display("FAIL reset_in_ready8 got %b want 0", in_ready_s); else passed++;
`ifdef ALU_PIPE_STICKY_EN
    total++; if (sticky_s !== 2'b00) $display("FAIL reset_sticky got %b want 00", sticky_s); else passed++;
`endif
    rst = 1'b0;
    #1;
    total++; if (in_ready_w !== 1'b1) $display("FAIL post_reset_in_ready64 got %b want 1", in_ready_w); else passed++;
    total++; if (in_ready_s !== 1'b1) $display("FAIL post_reset_in_ready8 got %b want 1", in_ready_s); else passed++;
  endtask

  task automatic test_add64();
    out_ready_w = 1'b1;
    issue64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'b10000);
    total++; if (out_valid_w !== 1'b1) $display("FAIL add_ovf_valid got %b want 1", out_valid_w); else passed++;
    total++; if (out_w !== 64'h8000_0000_0000_0000) $display("FAIL add_ovf_out got %h want 8000000000000000", out_w); else passed++;
    total++; if (status_w !== 4'b1100) $display("FAIL add_ovf_status got %b want 1100", status_w); else passed++;
    tick();
    total++; if (out_valid_w !== 1'b0) $display("FAIL add_consumed_valid got %b want 0", out_valid_w); else passed++;
    issue64(64'd5, 64'd5, 1'b1, 5'b10010);
    total++; if (out_w !== 64'd0) $display("FAIL sub_out got %h want 0", out_w); else passed++;
    total++; if (status_w !== 4'b0011) $display("FAIL sub_status got %b want 0011", status_w); else passed++;
  endtask

  task automatic test_logic_shift64();
    out_ready_w = 1'b1;
    issue64(64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_FFFF, 1'b0, 5'b01101);
    total++; if (out_w !== 64'hFFFF_FFFF_FFFF_F0F0) $display("FAIL xor_inva_out got %h want fffffffffffff0f0", out_w); else passed++;
    total++; if (status_w !== 4'b1000) $display("FAIL xor_inva_status got %b want 1000", status_w); else passed++;
    issue64(64'h8000_0000_0000_0000, 64'd63, 1'b0, 5'b10100);
    total++; if (out_w !== 64'd1) $display("FAIL shr63_out got %h want 1", out_w); else passed++;
    total++; if (out_valid_w !== 1'b1) $display("FAIL shr63_valid got %b want 1", out_valid_w); else passed++;
    issue64(64'h0000_0000_0000_00A5, 64'd64, 1'b0, 5'b11000);
    total++; if (out_w !== 64'h0000_0000_0000_00A5) $display("FAIL shl_masked_out got %h want a5", out_w); else passed++;
    total++; if (status_w !== 4'b0000) $display("FAIL shl_masked_status got %b want 0000", status_w); else passed++;
    issue64(64'd1, 64'd63, 1'b0, 5'b11000);
    total++; if (out_w !== 64'h8000_0000_0000_0000) $display("FAIL shl63_out got %h want 8000000000000000", out_w); else passed++;
    total++; if (status_w !== 4'b1000) $display("FAIL shl63_status got %b want 1000", status_w); else passed++;
    issue64(64'h1234, 64'h5678, 1'b1, 5'b00011);
    total++; if (status_w !== 4'b0001) $display("FAIL zero_op_status got %b want 0001", status_w); else passed++;
    tick();
  endtask

  task automatic test_mul8();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [4:0] ts [3];
    logic [7:0] eo [3];
    logic [3:0] es [3];
    ta[0] = 8'h10; tb[0] = 8'h11; ts[0] = 5'b11100; eo[0] = 8'h10; es[0] = 4'b0100;
    ta[1] = 8'h00; tb[1] = 8'h03; ts[1] = 5'b11101; eo[1] = 8'hFD; es[1] = 4'b1100;
    ta[2] = 8'h03; tb[2] = 8'h05; ts[2] = 5'b11100; eo[2] = 8'h0F; es[2] = 4'b0000;
    out_ready_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int cycles;
      int ready_bad;
      a_s = ta[i]; b_s = tb[i]; cin_s = 1'b0; sel_s = ts[i]; in_valid_s = 1'b1;
      #1;
      total++; if (in_ready_s !== 1'b1) $display("FAIL mul%0d_ready_before got %b want 1", i, in_ready_s); else passed++;
      tick();
      in_valid_s = 1'b0;
      cycles = 1;
      ready_bad = 0;
      while (out_valid_s !== 1'b1 && cycles < 40) begin
        if (in_ready_s !== 1'b0) ready_bad++;
        tick();
        cycles++;
      end
      total++; if (cycles != 9) $display("FAIL mul%0d_latency got %0d want 9", i, cycles); else passed++;
      total++; if (ready_bad != 0) $display("FAIL mul%0d_busy_ready got %0d ready cycles want 0", i, ready_bad); else passed++;
      total++; if (out_s !== eo[i]) $display("FAIL mul%0d_out got %h want %h", i, out_s, eo[i]); else passed++;
      total++; if (status_s !== es[i]) $display("FAIL mul%0d_status got %b want %b", i, status_s, es[i]); else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [4:0] ts [3];
    logic [7:0] eo [3];
    logic [3:0] es [3];
    int send;
    int recv;
    int cyc;
    int extra;
    logic fire_in;
    logic fire_out;
    ta[0] = 8'h0C; tb[0] = 8'h21; ts[0] = 5'b00100; eo[0] = 8'h2D; es[0] = 4'b0000;
    ta[1] = 8'hF0; tb[1] = 8'h9C; ts[1] = 5'b01000; eo[1] = 8'h90; es[1] = 4'b1000;
    ta[2] = 8'h0B; tb[2] = 8'h04; ts[2] = 5'b11000; eo[2] = 8'hB0; es[2] = 4'b1000;
    send = 0; recv = 0; cyc = 0; extra = 0;
    cin_s = 1'b0;
    while ((send < 3 || recv < 3) && cyc < 40) begin
      out_ready_s = (cyc >= 4);
      in_valid_s  = (send < 3);
      if (send < 3) begin
        a_s = ta[send]; b_s = tb[send]; sel_s = ts[send];
      end
      #1;
      if (out_valid_s === 1'b1 && out_ready_s === 1'b0 && recv < 3) begin
        total++; if (out_s !== eo[recv]) $display("FAIL bp_hold_out cyc %0d got %h want %h", cyc, out_s, eo[recv]); else passed++;
        total++; if (in_ready_s !== 1'b0) $display("FAIL bp_hold_in_ready cyc %0d got %b want 0", cyc, in_ready_s); else passed++;
      end
      fire_in  = in_valid_s & in_ready_s;
      fire_out = out_valid_s & out_ready_s;
      if (fire_out) begin
        if (recv < 3) begin
          total++; if (out_s !== eo[recv]) $display("FAIL bp_result%0d_out got %h want %h", recv, out_s, eo[recv]); else passed++;
          total++; if (status_s !== es[recv]) $display("FAIL bp_result%0d_status got %b want %b", recv, status_s, es[recv]); else passed++;
        end else begin
          extra++;
        end
        recv++;
      end
      if (fire_in) send++;
      tick();
      cyc++;
    end
    in_valid_s  = 1'b0;
    out_ready_s = 1'b1;
    #1;
    repeat (3) begin
      if (out_valid_s === 1'b1) extra++;
      tick();
    end
    total++; if (recv != 3) $display("FAIL bp_received got %0d want 3", recv); else passed++;
    total++; if (extra != 0) $display("FAIL bp_duplicates got %0d extra results want 0", extra); else passed++;
    total++; if (cyc != 7) $display("FAIL bp_cycles got %0d want 7", cyc); else passed++;
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    out_ready_s = 1'b1;
    issue8(8'h10, 8'h11, 1'b0, 5'b11100);
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++; if (out_valid_s !== 1'b0) $display("FAIL abort_out_valid got %b want 0", out_valid_s); else passed++;
    total++; if (out_s !== 8'h00) $display("FAIL abort_out got %h want 00", out_s); else passed++;
    total++; if (status_s !== 4'b0000) $display("FAIL abort_status got %b want 0000", status_s); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready_s !== 1'b1) $display("FAIL abort_in_ready got %b want 1", in_ready_s); else passed++;
`ifdef ALU_PIPE_STICKY_EN
    total++; if (sticky_s !== 2'b00) $display("FAIL abort_sticky got %b want 00", sticky_s); else passed++;
`endif
    stale = 0;
    repeat (12) begin
      if (out_valid_s === 1'b1) stale++;
      tick();
    end
    total++; if (stale != 0) $display("FAIL abort_stale got %0d valid cycles want 0", stale); else passed++;
  endtask

`ifdef ALU_PIPE_STICKY_EN
  task automatic test_sticky();
    out_ready_s = 1'b1;
    clr_sticky_s = 1'b0;
    issue8(8'hFF, 8'h01, 1'b0, 5'b10000);
    total++; if (status_s !== 4'b0011) $display("FAIL sticky_add_status got %b want 0011", status_s); else passed++;
    total++; if (sticky_s !== 2'b01) $display("FAIL sticky_after_carry got %b want 01", sticky_s); else passed++;
    issue8(8'hFF, 8'h0F, 1'b0, 5'b01000);
    total++; if (sticky_s !== 2'b01) $display("FAIL sticky_after_and got %b want 01", sticky_s); else passed++;
    clr_sticky_s = 1'b1;
    issue8(8'h7F, 8'h01, 1'b0, 5'b10000);
    clr_sticky_s = 1'b0;
    total++; if (sticky_s !== 2'b10) $display("FAIL sticky_clear_with_load got %b want 10", sticky_s); else passed++;
    clr_sticky_s = 1'b1;
    tick();
    clr_sticky_s = 1'b0;
    total++; if (sticky_s !== 2'b00) $display("FAIL sticky_clear_only got %b want 00", sticky_s); else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid_w = 1'b0; out_ready_w = 1'b1; cin_w = 1'b0; sel_w = '0; a_w = '0; b_w = '0;
    in_valid_s = 1'b0; out_ready_s = 1'b1; cin_s = 1'b0; sel_s = '0; a_s = '0; b_s = '0;
`ifdef ALU_PIPE_STICKY_EN
    clr_sticky_w = 1'b0;
    clr_sticky_s = 1'b0;
`endif
    test_reset();
    test_add64();
    test_logic_shift64();
    test_mul8();
    test_back_to_back();
    test_reset_mid_mul();
`ifdef ALU_PIPE_STICKY_EN
    test_sticky();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
